// File: rtl/hidden_seq_pkg.sv
// Shared types and helpers for the hidden-layer controller.
package hidden_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_LOAD_LAST = 3'd2,
        S_WAIT_IN   = 3'd3,
        S_COMPUTE   = 3'd4,
        S_OUT       = 3'd5
    } state_e;

    // Callers truncate the result to their strobe width (at most 32 perceptrons).
    function automatic logic [31:0] onehot32(input int idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/hidden_seq_if.sv
// Handshake and weight-load signals between the controller and its neighbours.
interface hidden_seq_if #(
    parameter int NUM_PCTN = 3,
    parameter int ADDR_W   = (NUM_PCTN > 1) ? $clog2(NUM_PCTN) : 1
);
    logic                i_load;
    logic [ADDR_W-1:0]   o_waddr;
    logic [NUM_PCTN-1:0] o_wr;
    logic                i_in_valid;
    logic                o_in_ready;
    logic                o_k_en;
    logic                o_out_valid;
    logic                i_out_ready;
    logic                o_busy;
    logic                o_loaded;

    modport slave (
        input  i_load, i_in_valid, i_out_ready,
        output o_waddr, o_wr, o_in_ready, o_k_en, o_out_valid, o_busy, o_loaded
    );

    modport master (
        output i_load, i_in_valid, i_out_ready,
        input  o_waddr, o_wr, o_in_ready, o_k_en, o_out_valid, o_busy, o_loaded
    );
endinterface

// File: rtl/hidden_seq_down_cnt.sv
// Loadable down counter with zero flag, used to time the layer's compute latency.
module seq_down_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/hidden_seq.sv
// Hidden-layer controller: streams weights into each perceptron, then sequences
// input capture, compute wait and output handshake.
module hidden_seq
    import hidden_seq_pkg::*;
#(
    parameter int NUM_PCTN = 3,
    parameter int LAT      = 2,
    parameter int ADDR_W   = (NUM_PCTN > 1) ? $clog2(NUM_PCTN) : 1
) (
    input  logic        clk,
    input  logic        rst,
    hidden_seq_if.slave bus
);
    localparam int CNT_W = $clog2(LAT + 1);
    // Entering COMPUTE already costs one cycle, so the counter starts at LAT-2.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LAT >= 2) ? (LAT - 2) : 0);
    localparam logic [ADDR_W-1:0] P_LAST  = ADDR_W'(NUM_PCTN - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   p_q, p_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [NUM_PCTN-1:0] wr_q, wr_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                loaded_q, loaded_d;
    logic                pend_q, pend_d;
    logic                capture;
    logic                cnt_load, cnt_en, cnt_zero;

    // A reload request in the same cycle wins over input capture.
    assign capture = (state_q == S_WAIT_IN) && bus.i_in_valid && !bus.i_load;

    seq_down_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (CNT_INIT),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        pend_d   = pend_q;
        loaded_d = loaded_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_load) begin
                    state_d = S_LOAD;
                    p_d     = '0;
                end
            end
            S_LOAD: begin
                if (p_q == P_LAST) begin
                    state_d = S_LOAD_LAST;
                end else begin
                    p_d = p_q + 1'b1;
                end
            end
            S_LOAD_LAST: begin
                loaded_d = 1'b1;
                state_d  = S_WAIT_IN;
            end
            S_WAIT_IN: begin
                if (bus.i_load) begin
                    state_d = S_LOAD;
                    p_d     = '0;
                end else if (capture) begin
                    cnt_load = 1'b1;
                    state_d  = (LAT == 1) ? S_OUT : S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (cnt_zero) begin
                    state_d = S_OUT;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_OUT: begin
                if (bus.i_load) begin
                    pend_d = 1'b1;
                end
                if (bus.i_out_ready) begin
                    if (pend_q || bus.i_load) begin
                        state_d = S_LOAD;
                        p_d     = '0;
                    end else begin
                        state_d = S_WAIT_IN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d == S_LOAD) && (state_q != S_LOAD)) begin
            pend_d = 1'b0;
        end

        // Outputs are registered, so they are derived from the next state.
        // ROM data lags the address by one cycle, hence strobe p-1 while addressing p.
        waddr_d = (state_d == S_LOAD) ? p_d : '0;
        wr_d    = '0;
        if ((state_d == S_LOAD) && (p_d != '0)) begin
            wr_d = NUM_PCTN'(onehot32(int'(p_d) - 1));
        end else if (state_d == S_LOAD_LAST) begin
            wr_d = NUM_PCTN'(onehot32(NUM_PCTN - 1));
        end
        in_ready_d  = (state_d == S_WAIT_IN);
        out_valid_d = (state_d == S_OUT);
        busy_d      = !((state_d == S_IDLE) || (state_d == S_WAIT_IN));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            p_q         <= '0;
            waddr_q     <= '0;
            wr_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            loaded_q    <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            waddr_q     <= waddr_d;
            wr_q        <= wr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            loaded_q    <= loaded_d;
            pend_q      <= pend_d;
        end
    end

    assign bus.o_waddr     = waddr_q;
    assign bus.o_wr        = wr_q;
    assign bus.o_in_ready  = in_ready_q;
    assign bus.o_k_en      = capture;
    assign bus.o_out_valid = out_valid_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_loaded    = loaded_q;
endmodule
